// File: rtl/seq_match_pkg.sv
// Shared types and helpers for the serial pattern match controller.
// The controller and its shift/compare block both import this package.
package seq_match_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2,
      TOUT  = 2'd3
   } state_t;

   localparam int DEF_MAX_LEN = 8;
   localparam int LEN_W       = $clog2(DEF_MAX_LEN) + 1;

   // A zero length means a single-bit pattern; anything too long is cut to the register size.
   function automatic int unsigned norm_len(input int unsigned len, input int unsigned max_len);
      if (len == 0) return 1;
      if (len > max_len) return max_len;
      return len;
   endfunction

   function automatic int unsigned norm_target(input int unsigned target);
      return (target == 0) ? 1 : target;
   endfunction

endpackage

// File: rtl/seq_match_ctrl_if.sv
// Config handshake, bit stream and status bundle between a host and seq_match_ctrl.
// The master modport is the host side; the slave modport is the controller.
interface seq_match_ctrl_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int TO_W    = 16
);
   localparam int LW = $clog2(MAX_LEN) + 1;

   logic               cfg_valid;
   logic               cfg_ready;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LW-1:0]      cfg_len;
   logic [CNT_W-1:0]   cfg_target;
   logic [TO_W-1:0]    cfg_timeout;
   logic               bit_in;
   logic               bit_vld;
   logic               abort;
   logic               done_ack;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               done;
   logic               timeout;
   logic [1:0]         state;

   modport master (
      output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
             bit_in, bit_vld, abort, done_ack,
      input  cfg_ready, match, match_cnt, done, timeout, state
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
             bit_in, bit_vld, abort, done_ack,
      output cfg_ready, match, match_cnt, done, timeout, state
   );

endinterface

// File: rtl/seq_shift_cmp.sv
// Serial shift register with a history counter and a length-masked pattern compare.
// hit is combinational and looks at the register value that the current shift will produce.
module seq_shift_cmp #(
   parameter int MAX_LEN = 8,
   parameter int LW      = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               shift,
   input  logic               bit_in,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LW-1:0]      len,
   output logic               hit
);

   logic [MAX_LEN-1:0] shreg;
   logic [MAX_LEN-1:0] shreg_next;
   logic [MAX_LEN-1:0] mask;
   logic [LW-1:0]      hist;
   logic [LW:0]        hist_inc;
   logic               full;

   // The history counter stops at len, so a hit needs at least len qualified bits since arming.
   always_comb begin
      shreg_next = {shreg[MAX_LEN-2:0], bit_in};
      hist_inc   = {1'b0, hist} + (LW+1)'(1);
      full       = (hist_inc >= {1'b0, len});
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
      hit = shift && full && (((shreg_next ^ pattern) & mask) == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         shreg <= '0;
         hist  <= '0;
      end else if (clr) begin
         shreg <= '0;
         hist  <= '0;
      end else if (shift) begin
         shreg <= shreg_next;
         hist  <= full ? len : hist_inc[LW-1:0];
      end
   end

endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial-pattern match controller: takes one job through the config
// handshake, counts overlapping hits on the qualified bit stream and reports done or timeout.
module seq_match_ctrl
   import seq_match_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int TO_W    = 16
) (
   input logic             clk,
   input logic             reset,
   seq_match_ctrl_if.slave bus
);

   localparam int LW = $clog2(MAX_LEN) + 1;

   state_t             state_q;
   state_t             state_next;
   logic [MAX_LEN-1:0] pattern_q;
   logic [LW-1:0]      len_q;
   logic [CNT_W-1:0]   target_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic [TO_W-1:0]    limit_q;
   logic [TO_W-1:0]    to_q;
   logic [TO_W-1:0]    to_inc;
   logic               accept;
   logic               shift;
   logic               hit;
   logic               match_q;

   assign accept  = (state_q == IDLE) && bus.cfg_valid;
   assign shift   = (state_q == ARMED) && bus.bit_vld && !bus.abort;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign to_inc  = to_q + 1'b1;

   seq_shift_cmp #(
      .MAX_LEN(MAX_LEN),
      .LW     (LW)
   ) u_cmp (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept),
      .shift  (shift),
      .bit_in (bus.bit_in),
      .pattern(pattern_q),
      .len    (len_q),
      .hit    (hit)
   );

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_next;
   end

   // A hit that reaches the target wins over a timeout expiring on the same bit.
   always_comb begin
      state_next = state_q;
      case (state_q)
         IDLE:  if (bus.cfg_valid) state_next = ARMED;
         ARMED: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else if (shift) begin
               if (hit) begin
                  if (cnt_inc == target_q) state_next = DONE;
               end else if ((limit_q != '0) && (to_inc == limit_q)) begin
                  state_next = TOUT;
               end
            end
         end
         DONE, TOUT: if (bus.abort || bus.done_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pattern_q <= '0;
         len_q     <= '0;
         target_q  <= '0;
         limit_q   <= '0;
         cnt_q     <= '0;
         to_q      <= '0;
         match_q   <= 1'b0;
      end else begin
         match_q <= 1'b0;
         if (accept) begin
            pattern_q <= bus.cfg_pattern;
            len_q     <= LW'(norm_len(32'(bus.cfg_len), 32'(MAX_LEN)));
            target_q  <= CNT_W'(norm_target(32'(bus.cfg_target)));
            limit_q   <= bus.cfg_timeout;
            cnt_q     <= '0;
            to_q      <= '0;
         end else if ((state_q != IDLE) && bus.abort) begin
            cnt_q <= '0;
            to_q  <= '0;
         end else if (shift) begin
            if (hit) begin
               match_q <= 1'b1;
               cnt_q   <= cnt_inc;
               to_q    <= '0;
            end else begin
               to_q <= to_inc;
            end
         end
      end
   end

   assign bus.cfg_ready = (state_q == IDLE);
   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
   assign bus.done      = (state_q == DONE);
   assign bus.timeout   = (state_q == TOUT);
   assign bus.state     = state_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the matching rules.
module tb_seq_match_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: bit history is a plain queue, newest bit at the back.
   int         m_state;
   bit         m_match;
   int         m_cnt;
   int         m_since;
   int         m_len;
   int         m_target;
   int         m_limit;
   logic [7:0] m_pat;
   bit         hq[$];

   seq_match_ctrl_if #(.MAX_LEN(8), .CNT_W(8), .TO_W(16)) bus ();

   seq_match_ctrl #(.MAX_LEN(8), .CNT_W(8), .TO_W(16)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bit patternSeen();
      if (hq.size() < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         if (hq[hq.size()-1-i] != m_pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void modelEdge();
      m_match = 1'b0;
      if (!reset) begin
         m_state = 0;
         m_cnt   = 0;
         m_since = 0;
         hq.delete();
         return;
      end
      case (m_state)
         0: if (bus.cfg_valid) begin
               m_pat    = bus.cfg_pattern;
               m_len    = (bus.cfg_len == 0) ? 1 : ((bus.cfg_len > 8) ? 8 : int'(bus.cfg_len));
               m_target = (bus.cfg_target == 0) ? 1 : int'(bus.cfg_target);
               m_limit  = int'(bus.cfg_timeout);
               m_cnt    = 0;
               m_since  = 0;
               hq.delete();
               m_state  = 1;
            end
         1: if (bus.abort) begin
               m_state = 0;
               m_cnt   = 0;
            end else if (bus.bit_vld) begin
               hq.push_back(bus.bit_in);
               if (hq.size() > 16) void'(hq.pop_front());
               if (patternSeen()) begin
                  m_match = 1'b1;
                  if (m_cnt < 255) m_cnt++;
                  m_since = 0;
                  if (m_cnt == m_target) m_state = 2;
               end else begin
                  m_since++;
                  if (m_limit != 0 && m_since == m_limit) m_state = 3;
               end
            end
         default: if (bus.abort) begin
               m_state = 0;
               m_cnt   = 0;
            end else if (bus.done_ack) begin
               m_state = 0;
            end
      endcase
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("state",     32'(bus.state),     32'(m_state));
      checkOutput("cfg_ready", 32'(bus.cfg_ready), 32'(m_state == 0));
      checkOutput("match",     32'(bus.match),     32'(m_match));
      checkOutput("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
      checkOutput("done",      32'(bus.done),      32'(m_state == 2));
      checkOutput("timeout",   32'(bus.timeout),   32'(m_state == 3));
   endtask

   task automatic applyStimulus(input logic cv, input logic bv, input logic b,
                                input logic ab, input logic ack);
      bus.cfg_valid = cv;
      bus.bit_vld   = bv;
      bus.bit_in    = b;
      bus.abort     = ab;
      bus.done_ack  = ack;
      stepCycle();
   endtask

   task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                            input logic [7:0] tgt, input logic [15:0] to);
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_target  = tgt;
      bus.cfg_timeout = to;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Sends n bits most-significant first, each qualified.
   task automatic sendBits(input logic [15:0] bits, input int n);
      logic [15:0] v;
      v = bits;
      for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b1, v[i], 1'b0, 1'b0);
   endtask

   task automatic ackJob();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
      bus.cfg_target = '0;  bus.cfg_timeout = '0; bus.bit_in = 1'b0;
      bus.bit_vld = 1'b0;   bus.abort = 1'b0;     bus.done_ack = 1'b0;
      m_state = 0; m_cnt = 0; m_since = 0; m_match = 1'b0;
      m_len = 1; m_target = 1; m_limit = 0; m_pat = '0;

      stepCycle();
      stepCycle();
      reset = 1'b1;
      stepCycle();

      // Basic hit, then stream and config ignored while DONE
      configure(8'b0111_0010, 4'd7, 8'd1, 16'd0);
      sendBits(16'b111_0010, 7);
      bus.cfg_pattern = 8'hFF;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ackJob();

      // Overlapping matches
      configure(8'b101, 4'd3, 8'd2, 16'd0);
      sendBits(16'b10101, 5);
      ackJob();

      // Timeout
      configure(8'b1111, 4'd4, 8'd1, 16'd5);
      sendBits(16'b00000, 5);
      ackJob();

      // Gaps in bit_vld: unqualified bits carry garbage
      configure(8'b101, 4'd3, 8'd1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      ackJob();

      // len=0 acts as a one-bit pattern; target=0 acts as one hit
      configure(8'b0000_0001, 4'd0, 8'd3, 16'd0);
      sendBits(16'b0111, 4);
      ackJob();
      configure(8'b11, 4'd2, 8'd0, 16'd0);
      sendBits(16'b11, 2);
      ackJob();

      // Oversized len is clamped to the register width
      configure(8'b1010_1010, 4'd15, 8'd1, 16'd0);
      sendBits(16'b1010_1010, 8);
      ackJob();

      // Abort mid-job, then a fresh config with cfg_valid held while ARMED
      configure(8'b0111_0010, 4'd7, 8'd1, 16'd0);
      sendBits(16'b111, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      configure(8'b11, 4'd2, 8'd1, 16'd0);
      bus.cfg_pattern = 8'b00;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      bus.cfg_valid = 1'b0;
      ackJob();

      // Synchronous reset mid-job
      configure(8'b0111_0010, 4'd7, 8'd1, 16'd0);
      sendBits(16'b111, 3);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         reset = (r < 2) ? 1'b0 : 1'b1;
         bus.cfg_pattern = 8'($urandom);
         bus.cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         bus.cfg_target  = 8'($urandom_range(0, 3));
         bus.cfg_timeout = 16'($urandom_range(0, 8));
         applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                       1'($urandom), 1'(r >= 2 && r < 4), 1'($urandom_range(0, 4) == 0));
      end
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
